// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / flow-control unit:
// forwarding mux encodings, halt FSM state type and counter indices.
package pipeline_ctrl_pkg;

    // ID-stage operand forwarding mux select encodings
    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_EX      = 2'd1;
    localparam logic [1:0] FWD_MEM     = 2'd2;

    // Syscall halt/resume FSM
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Performance counter slots
    localparam int NUM_CNT     = 5;
    localparam int CNT_CYCLES  = 0;
    localparam int CNT_RETIRED = 1;
    localparam int CNT_BRANCH  = 2;
    localparam int CNT_JUMP    = 3;
    localparam int CNT_STALL   = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_src_cmp.sv
// Per-source RAW hazard comparator: matches one ID-stage source register
// against the EX and MEM destinations and reports whether the source must
// bubble. Build option PIPELINE_HAZARD_FWD_EN selects forwarding mode
// (only loads bubble) versus legacy mode (every producer match bubbles).
module hazard_src_cmp #(
    parameter int REG_AW = 5
) (
    input  logic              src_used,
    input  logic [REG_AW-1:0] src_reg,
    input  logic              ex_regwrite,
    input  logic              ex_memtoreg,
    input  logic [REG_AW-1:0] ex_wreg,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_wreg,
    output logic              ex_match,
    output logic              mem_match,
    output logic              load_use
);

    logic src_live;

    // Register 0 is hard-wired, so it never carries a dependency
    always_comb begin
        src_live  = src_used && (src_reg != '0);
        ex_match  = src_live && ex_regwrite  && (src_reg == ex_wreg);
        mem_match = src_live && mem_regwrite && (src_reg == mem_wreg);
    end

    // Decide whether this source has to wait a cycle
    always_comb begin
`ifdef PIPELINE_HAZARD_FWD_EN
        // Load data only exists after MEM, so an EX load cannot be forwarded
        load_use = ex_match && ex_memtoreg;
`else
        // Legacy bubbling: any in-flight producer stalls; a load is just
        // one kind of EX write and folds into the plain match
        load_use = ex_match || mem_match || (ex_match && ex_memtoreg);
`endif
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and flow-control unit for the 5-stage MIPS pipeline: RAW detection,
// ID-stage forwarding select, load-use bubbles, branch/jump flushes, syscall
// halt/resume FSM and saturating performance counters.
// Build option: PIPELINE_HAZARD_FWD_EN enables forwarding; when undefined,
// fwd_sel is tied to the regfile and every EX/MEM match bubbles.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      go,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_reg,
    input  logic                      ex_valid,
    input  logic                      ex_regwrite,
    input  logic                      ex_memtoreg,
    input  logic [REG_AW-1:0]         ex_wreg,
    input  logic                      mem_regwrite,
    input  logic [REG_AW-1:0]         mem_wreg,
    input  logic                      ex_branch_taken,
    input  logic                      ex_jump,
    input  logic                      ex_syscall_halt,
    output logic                      pc_en,
    output logic                      if_id_en,
    output logic                      if_id_flush,
    output logic                      id_ex_flush,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      halted,
    output logic [CNT_W-1:0]          cnt_cycles,
    output logic [CNT_W-1:0]          cnt_retired,
    output logic [CNT_W-1:0]          cnt_branch,
    output logic [CNT_W-1:0]          cnt_jump,
    output logic [CNT_W-1:0]          cnt_stall
);

    state_e             state_q, state_d;
    logic               go_q, go_d;
    logic [CNT_W-1:0]   cnt_q [NUM_CNT];
    logic [CNT_W-1:0]   cnt_d [NUM_CNT];
    logic [NUM_CNT-1:0] cnt_inc;

    logic [NUM_SRC-1:0] src_ex_match;
    logic [NUM_SRC-1:0] src_mem_match;
    logic [NUM_SRC-1:0] src_load_use;

    logic run;
    logic halt_entry;
    logic go_rise;
    logic ctrl_hz;
    logic stall_req;
    logic stall_bubble;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_src_cmp #(
            .REG_AW (REG_AW)
        ) u_cmp (
            .src_used     (id_src_used[i]),
            .src_reg      (id_src_reg[i*REG_AW +: REG_AW]),
            .ex_regwrite  (ex_regwrite),
            .ex_memtoreg  (ex_memtoreg),
            .ex_wreg      (ex_wreg),
            .mem_regwrite (mem_regwrite),
            .mem_wreg     (mem_wreg),
            .ex_match     (src_ex_match[i]),
            .mem_match    (src_mem_match[i]),
            .load_use     (src_load_use[i])
        );
    end

    // Forwarding selects and the combined stall request
    always_comb begin
        fwd_sel = '0;
`ifdef PIPELINE_HAZARD_FWD_EN
        // EX is the younger producer, so it wins over MEM; a stalled
        // source keeps the regfile select since the bubble discards it
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_ex_match[i]) begin
                fwd_sel[2*i +: 2] = ex_memtoreg ? FWD_REGFILE : FWD_EX;
            end else if (src_mem_match[i]) begin
                fwd_sel[2*i +: 2] = FWD_MEM;
            end
        end
        stall_req = |src_load_use;
`else
        stall_req = |(src_load_use | src_ex_match | src_mem_match);
`endif
    end

    // Event decode shared by the control outputs, FSM and counters
    always_comb begin
        run        = (state_q == ST_RUN);
        halt_entry = run && ex_syscall_halt && ex_valid;
        go_rise    = go && !go_q;
        ctrl_hz    = ex_branch_taken || ex_jump;
    end

    // Pipeline control: halt > branch/jump flush > load-use bubble
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        stall_bubble = 1'b0;
        if (!run || halt_entry) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (ctrl_hz) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (stall_req) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_flush  = 1'b1;
            stall_bubble = 1'b1;
        end
        halted = !run;
    end

    // Halt FSM next state; go is edge-detected so a held button never resumes
    always_comb begin
        state_d = state_q;
        go_d    = go;
        case (state_q)
            ST_RUN:  if (halt_entry) state_d = ST_HALT;
            ST_HALT: if (go_rise)    state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Counter increments: everything freezes outside RUN, values saturate
    always_comb begin
        cnt_inc              = '0;
        cnt_inc[CNT_CYCLES]  = run;
        cnt_inc[CNT_RETIRED] = run && ex_valid;
        cnt_inc[CNT_BRANCH]  = run && ex_branch_taken;
        cnt_inc[CNT_JUMP]    = run && ex_jump;
        cnt_inc[CNT_STALL]   = stall_bubble;
        for (int k = 0; k < NUM_CNT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (cnt_inc[k] && !(&cnt_q[k])) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    // State, go history and counters; clr beats every same-cycle event
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_RUN;
            go_q    <= 1'b0;
            for (int k = 0; k < NUM_CNT; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
            for (int k = 0; k < NUM_CNT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign cnt_cycles  = cnt_q[CNT_CYCLES];
    assign cnt_retired = cnt_q[CNT_RETIRED];
    assign cnt_branch  = cnt_q[CNT_BRANCH];
    assign cnt_jump    = cnt_q[CNT_JUMP];
    assign cnt_stall   = cnt_q[CNT_STALL];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Counters are narrowed to 4 bits
// so saturation is reachable. Control outputs are compared as the vector
// {pc_en, if_id_en, if_id_flush, id_ex_flush, halted}.
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;
    localparam int CNT_W   = 4;
`ifdef PIPELINE_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      clr;
    logic                      go;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [NUM_SRC*REG_AW-1:0] id_src_reg;
    logic                      ex_valid, ex_regwrite, ex_memtoreg;
    logic [REG_AW-1:0]         ex_wreg;
    logic                      mem_regwrite;
    logic [REG_AW-1:0]         mem_wreg;
    logic                      ex_branch_taken, ex_jump, ex_syscall_halt;
    logic                      pc_en, if_id_en, if_id_flush, id_ex_flush, halted;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic [CNT_W-1:0]          cnt_cycles, cnt_retired, cnt_branch, cnt_jump, cnt_stall;
    logic [4:0]                ctl;

    int n_cmp = 0;
    int n_err = 0;

    assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_flush, halted};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_AW  (REG_AW),
        .NUM_SRC (NUM_SRC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk             (clk),
        .clr             (clr),
        .go              (go),
        .id_src_used     (id_src_used),
        .id_src_reg      (id_src_reg),
        .ex_valid        (ex_valid),
        .ex_regwrite     (ex_regwrite),
        .ex_memtoreg     (ex_memtoreg),
        .ex_wreg         (ex_wreg),
        .mem_regwrite    (mem_regwrite),
        .mem_wreg        (mem_wreg),
        .ex_branch_taken (ex_branch_taken),
        .ex_jump         (ex_jump),
        .ex_syscall_halt (ex_syscall_halt),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .fwd_sel         (fwd_sel),
        .halted          (halted),
        .cnt_cycles      (cnt_cycles),
        .cnt_retired     (cnt_retired),
        .cnt_branch      (cnt_branch),
        .cnt_jump        (cnt_jump),
        .cnt_stall       (cnt_stall)
    );

    task automatic idle();
        id_src_used     = '0;
        id_src_reg      = '0;
        ex_valid        = 1'b0;
        ex_regwrite     = 1'b0;
        ex_memtoreg     = 1'b0;
        ex_wreg         = '0;
        mem_regwrite    = 1'b0;
        mem_wreg        = '0;
        ex_branch_taken = 1'b0;
        ex_jump         = 1'b0;
        ex_syscall_halt = 1'b0;
    endtask

    // Ends on a negedge with clr low and counters freshly cleared
    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        go  = 1'b0;
        idle();
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        do_clr();
        #1;
        n_cmp++;
        if (ctl !== 5'b11000) begin n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, 5'b11000); end
        n_cmp++;
        if (fwd_sel !== 4'b0000) begin n_err++; $display("FAIL reset_fwd: got %b want 0000", fwd_sel); end
        n_cmp++;
        if ({cnt_cycles, cnt_retired, cnt_branch, cnt_jump, cnt_stall} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_cnt: got %h want 00000", {cnt_cycles, cnt_retired, cnt_branch, cnt_jump, cnt_stall});
        end
    endtask

    // add $t0 in EX, ID reads $t0 on source 0
    task automatic test_fwd_ex();
        do_clr();
        id_src_used = 2'b01;
        id_src_reg  = {5'd0, 5'd8};
        ex_valid    = 1'b1;
        ex_regwrite = 1'b1;
        ex_wreg     = 5'd8;
        #1;
        n_cmp++;
        if (fwd_sel !== (FWD ? 4'b0001 : 4'b0000)) begin n_err++; $display("FAIL fwd_ex_sel: got %b want %b", fwd_sel, FWD ? 4'b0001 : 4'b0000); end
        n_cmp++;
        if (ctl !== (FWD ? 5'b11000 : 5'b00010)) begin n_err++; $display("FAIL fwd_ex_ctl: got %b want %b", ctl, FWD ? 5'b11000 : 5'b00010); end
        @(negedge clk);
        idle();
        n_cmp++;
        if ({cnt_cycles, cnt_retired, cnt_stall} !== (FWD ? 12'h110 : 12'h111)) begin
            n_err++;
            $display("FAIL fwd_ex_cnt: got %h want %h", {cnt_cycles, cnt_retired, cnt_stall}, FWD ? 12'h110 : 12'h111);
        end
    endtask

    // lw $t0 in EX, ID reads $t0 on source 1; next cycle the load is in MEM
    task automatic test_load_use();
        do_clr();
        id_src_used = 2'b10;
        id_src_reg  = {5'd8, 5'd0};
        ex_valid    = 1'b1;
        ex_regwrite = 1'b1;
        ex_memtoreg = 1'b1;
        ex_wreg     = 5'd8;
        #1;
        n_cmp++;
        if (ctl !== 5'b00010) begin n_err++; $display("FAIL lu_stall_ctl: got %b want 00010", ctl); end
        @(negedge clk);
        ex_valid     = 1'b0;
        ex_regwrite  = 1'b0;
        ex_memtoreg  = 1'b0;
        ex_wreg      = 5'd0;
        mem_regwrite = 1'b1;
        mem_wreg     = 5'd8;
        #1;
        n_cmp++;
        if (fwd_sel !== (FWD ? 4'b1000 : 4'b0000)) begin n_err++; $display("FAIL lu_mem_fwd: got %b want %b", fwd_sel, FWD ? 4'b1000 : 4'b0000); end
        n_cmp++;
        if (ctl !== (FWD ? 5'b11000 : 5'b00010)) begin n_err++; $display("FAIL lu_mem_ctl: got %b want %b", ctl, FWD ? 5'b11000 : 5'b00010); end
        @(negedge clk);
        idle();
        n_cmp++;
        if ({cnt_cycles, cnt_retired, cnt_stall} !== (FWD ? 12'h211 : 12'h212)) begin
            n_err++;
            $display("FAIL lu_cnt: got %h want %h", {cnt_cycles, cnt_retired, cnt_stall}, FWD ? 12'h211 : 12'h212);
        end
    endtask

    // Taken branch over a load-use, then a jump over a plain EX match
    task automatic test_ctrl_hazard();
        do_clr();
        id_src_used     = 2'b10;
        id_src_reg      = {5'd8, 5'd0};
        ex_valid        = 1'b1;
        ex_regwrite     = 1'b1;
        ex_memtoreg     = 1'b1;
        ex_wreg         = 5'd8;
        ex_branch_taken = 1'b1;
        #1;
        n_cmp++;
        if ((ctl | 5'b01000) !== 5'b11110) begin n_err++; $display("FAIL br_lu_ctl: got %b want 1x110", ctl); end
        @(negedge clk);
        idle();
        id_src_used = 2'b01;
        id_src_reg  = {5'd0, 5'd9};
        ex_valid    = 1'b1;
        ex_regwrite = 1'b1;
        ex_wreg     = 5'd9;
        ex_jump     = 1'b1;
        #1;
        n_cmp++;
        if ((ctl | 5'b01000) !== 5'b11110) begin n_err++; $display("FAIL jump_ctl: got %b want 1x110", ctl); end
        @(negedge clk);
        idle();
        n_cmp++;
        if ({cnt_branch, cnt_jump, cnt_stall} !== 12'h110) begin
            n_err++;
            $display("FAIL ctrl_cnt: got %h want 110", {cnt_branch, cnt_jump, cnt_stall});
        end
    endtask

    // Register 0 never matches, even against a load in EX and a MEM write
    task automatic test_reg0();
        do_clr();
        id_src_used  = 2'b11;
        id_src_reg   = '0;
        ex_valid     = 1'b1;
        ex_regwrite  = 1'b1;
        ex_memtoreg  = 1'b1;
        ex_wreg      = 5'd0;
        mem_regwrite = 1'b1;
        mem_wreg     = 5'd0;
        #1;
        n_cmp++;
        if ({ctl, fwd_sel} !== 9'b11000_0000) begin n_err++; $display("FAIL reg0: got %b want 110000000", {ctl, fwd_sel}); end
        @(negedge clk);
        idle();
        n_cmp++;
        if (cnt_stall !== 4'd0) begin n_err++; $display("FAIL reg0_stall: got %0d want 0", cnt_stall); end
    endtask

    // Mixed EX/MEM sources, EX-over-MEM priority, and non-matching cases
    task automatic test_mem_priority();
        do_clr();
        id_src_used  = 2'b11;
        id_src_reg   = {5'd10, 5'd9};
        ex_valid     = 1'b1;
        ex_regwrite  = 1'b1;
        ex_wreg      = 5'd9;
        mem_regwrite = 1'b1;
        mem_wreg     = 5'd10;
        #1;
        n_cmp++;
        if ({ctl, fwd_sel} !== (FWD ? 9'b11000_1001 : 9'b00010_0000)) begin
            n_err++;
            $display("FAIL mix_src: got %b want %b", {ctl, fwd_sel}, FWD ? 9'b11000_1001 : 9'b00010_0000);
        end
        @(negedge clk);
        id_src_used = 2'b01;
        id_src_reg  = {5'd0, 5'd9};
        mem_wreg    = 5'd9;
        #1;
        n_cmp++;
        if ({ctl, fwd_sel} !== (FWD ? 9'b11000_0001 : 9'b00010_0000)) begin
            n_err++;
            $display("FAIL ex_over_mem: got %b want %b", {ctl, fwd_sel}, FWD ? 9'b11000_0001 : 9'b00010_0000);
        end
        @(negedge clk);
        ex_regwrite  = 1'b0;
        mem_regwrite = 1'b0;
        #1;
        n_cmp++;
        if ({ctl, fwd_sel} !== 9'b11000_0000) begin n_err++; $display("FAIL no_regwrite: got %b want 110000000", {ctl, fwd_sel}); end
        @(negedge clk);
        ex_regwrite = 1'b1;
        ex_memtoreg = 1'b1;
        id_src_used = 2'b00;
        #1;
        n_cmp++;
        if ({ctl, fwd_sel} !== 9'b11000_0000) begin n_err++; $display("FAIL src_unused: got %b want 110000000", {ctl, fwd_sel}); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_halt();
        do_clr();
        ex_valid        = 1'b1;
        ex_syscall_halt = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 5'b00010) begin n_err++; $display("FAIL halt_entry_ctl: got %b want 00010", ctl); end
        @(negedge clk);
        idle();
        ex_valid = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 5'b00011) begin n_err++; $display("FAIL halted_ctl: got %b want 00011", ctl); end
        repeat (20) @(negedge clk);
        n_cmp++;
        if ({ctl, cnt_cycles, cnt_retired} !== {5'b00011, 8'h11}) begin
            n_err++;
            $display("FAIL halt_frozen: got %b/%h want 00011/11", ctl, {cnt_cycles, cnt_retired});
        end
        ex_valid = 1'b0;
        go       = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ctl, cnt_cycles} !== {5'b11000, 4'd1}) begin n_err++; $display("FAIL resume: got %b/%0d want 11000/1", ctl, cnt_cycles); end
        @(negedge clk);
        n_cmp++;
        if (cnt_cycles !== 4'd2) begin n_err++; $display("FAIL resume_count: got %0d want 2", cnt_cycles); end
        ex_valid        = 1'b1;
        ex_syscall_halt = 1'b1;
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ctl, cnt_cycles, cnt_retired} !== {5'b00011, 8'h32}) begin
            n_err++;
            $display("FAIL go_held: got %b/%h want 00011/32", ctl, {cnt_cycles, cnt_retired});
        end
        go = 1'b0;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ctl, cnt_cycles} !== {5'b11000, 4'd3}) begin n_err++; $display("FAIL second_resume: got %b/%0d want 11000/3", ctl, cnt_cycles); end
        go = 1'b0;
    endtask

    task automatic test_clr_in_halt();
        do_clr();
        ex_valid        = 1'b1;
        ex_syscall_halt = 1'b1;
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (ctl !== 5'b00011) begin n_err++; $display("FAIL clr_pre_halt: got %b want 00011", ctl); end
        @(negedge clk);
        go  = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        n_cmp++;
        if ({ctl, cnt_cycles, cnt_retired, cnt_branch, cnt_jump, cnt_stall} !== {5'b11000, 20'h0}) begin
            n_err++;
            $display("FAIL clr_in_halt: got %b/%h want 11000/00000", ctl,
                     {cnt_cycles, cnt_retired, cnt_branch, cnt_jump, cnt_stall});
        end
        go = 1'b0;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ctl !== 5'b11000) begin n_err++; $display("FAIL go_in_run: got %b want 11000", ctl); end
        go = 1'b0;
    endtask

    task automatic test_saturation();
        do_clr();
        ex_valid = 1'b1;
        repeat (17) @(negedge clk);
        n_cmp++;
        if ({cnt_cycles, cnt_retired} !== 8'hFF) begin n_err++; $display("FAIL sat_17: got %h want ff", {cnt_cycles, cnt_retired}); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cnt_cycles, cnt_retired, cnt_stall} !== 12'hFF0) begin
            n_err++;
            $display("FAIL sat_hold: got %h want ff0", {cnt_cycles, cnt_retired, cnt_stall});
        end
        idle();
    endtask

    initial begin
        clr = 1'b1;
        go  = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        test_reset();
        test_fwd_ex();
        test_load_use();
        test_ctrl_hazard();
        test_reg0();
        test_mem_priority();
        test_halt();
        test_clr_in_halt();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard and flow-control unit for the 5-stage MIPS pipeline. It is the successor to the bubble-only scheme.
- Detects RAW hazards between ID-stage sources and the EX/MEM destinations.
- Selects ID-stage operand forwarding, or inserts load-use bubbles.
- Flushes IF/ID and ID/EX on taken branch or jump resolved in EX.
- Runs the syscall halt/resume FSM and the performance counters (cycles, retired, branch, jump, stall).

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, number of ID-stage source operands checked
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock, rising edge
clr  in  1  reset, synchronous, active-high
go  in  1  resume button level (asynchronous to program, synchronised upstream)
id_src_used  in  NUM_SRC  source i is read by the ID instruction
id_src_reg  in  NUM_SRC*REG_AW  source i register number, source 0 in LSBs
ex_valid  in  1  EX holds a real instruction (not a bubble)
ex_regwrite  in  1  EX instruction writes the register file
ex_memtoreg  in  1  EX instruction is a load
ex_wreg  in  REG_AW  EX destination register
mem_regwrite  in  1  MEM instruction writes the register file
mem_wreg  in  REG_AW  MEM destination register
ex_branch_taken  in  1  conditional branch taken in EX
ex_jump  in  1  j/jal/jr in EX
ex_syscall_halt  in  1  syscall with halt code in EX
pc_en  out  1  PC load enable
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  load a bubble into IF/ID
id_ex_flush  out  1  load a bubble into ID/EX
fwd_sel  out  NUM_SRC*2  per source: 0 = regfile, 1 = EX result, 2 = MEM result
halted  out  1  FSM in HALT
cnt_cycles, cnt_retired, cnt_branch, cnt_jump, cnt_stall  out  CNT_W each  performance counters

Behaviour:
- Reset values: FSM = RUN, all counters 0, go_q = 0. Outputs after reset: pc_en = 1, if_id_en = 1, flushes 0, fwd_sel 0, halted = 0.
- Control outputs are combinational from inputs and state. Counters and FSM update on the clk edge.
- Match rule for source i: id_src_used[i] & reg != 0 & reg == wreg & regwrite. Register 0 never matches.
- Forwarding: EX match wins over MEM match. EX match with ex_memtoreg = 1 does not forward; it raises load-use.
- Load-use stall, when any source has an EX-load match:
  - pc_en = 0, if_id_en = 0, id_ex_flush = 1.
  - fwd_sel for the stalled sources is don't-care.
- Control hazard (ex_branch_taken | ex_jump):
  - pc_en = 1, if_id_flush = 1, id_ex_flush = 1.
  - Overrides load-use; no stall is counted that cycle.
- Halt FSM, RUN -> HALT:
  - Entry: ex_syscall_halt & ex_valid in RUN.
  - Entry cycle: pc_en = 0, if_id_en = 0, id_ex_flush = 1. Halt takes priority over branch, jump and load-use.
  - In HALT: pc_en = 0, if_id_en = 0, id_ex_flush = 1, halted = 1. MEM/WB continue to drain.
- Resume, HALT -> RUN: on a rising edge of go (go & ~go_q); go_q is registered every cycle. A go edge in RUN is ignored. A go held high across halt entry does not resume; a new edge is required.
- Counters (all saturate at all-ones, all hold in HALT):
  - cnt_cycles: +1 every RUN cycle.
  - cnt_retired: +1 when ex_valid in RUN, including the halting syscall.
  - cnt_branch: +1 on ex_branch_taken.
  - cnt_jump: +1 on ex_jump.
  - cnt_stall: +1 on each load-use bubble cycle.
- clr overrides all events in the same cycle, including mid-halt and a simultaneous go edge.

Optional Feature:
- Macro: PIPELINE_HAZARD_FWD_EN.
- Defined: forwarding as above; only load-use stalls.
- Undefined: fwd_sel tied 0. Any EX or MEM match (regwrite, any opcode) stalls with the load-use outputs and increments cnt_stall. This is the legacy bubbling behaviour.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - FWD_REGFILE = 2'd0, FWD_EX = 2'd1, FWD_MEM = 2'd2.
  - FSM state type {ST_RUN, ST_HALT}.
- One sub-module, hazard_src_cmp, instantiated NUM_SRC times. Per source it produces ex_match, mem_match and load_use.

Test Plan:
- ID uses $t0 (reg 8), EX is add writing 8 -> fwd_sel[1:0] = 1, pc_en = 1, cnt_stall unchanged.
- EX is lw writing 8, ID uses 8 as src1 -> one cycle with pc_en = 0, if_id_en = 0, id_ex_flush = 1, cnt_stall +1. Next cycle (load in MEM) fwd_sel[3:2] = 2.
- EX lw writes 8, ID uses 8, ex_branch_taken = 1 same cycle -> if_id_flush = 1, id_ex_flush = 1, pc_en = 1, cnt_branch +1, cnt_stall +0.
- ID src reg 0, EX writes 0 -> fwd_sel = 0, no stall.
- ex_syscall_halt with ex_valid -> halted = 1 next cycle, counters frozen for 20 cycles. A go rising edge gives halted = 0 next cycle and cnt_cycles resumes. go held high gives no second resume.
- clr asserted in HALT with go edge same cycle -> state RUN, all counters 0. Compile without PIPELINE_HAZARD_FWD_EN: the first case stalls one cycle with fwd_sel = 0.
